// File: rtl/gyro_rate_deriv.sv
// Reconstructs per-sample angular rate from 3-axis tilt: (cur - prev) / RATE,
// using one shared restoring divider that walks the axes X, Y, Z in turn.
module gyro_rate_deriv #(
  parameter int RATE  = 10,
  parameter int WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  input  logic signed [WIDTH-1:0] Z,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] dx,
  output logic signed [WIDTH-1:0] dy,
  output logic signed [WIDTH-1:0] dz,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {IDLE, SUB, DIV, OUT} state_t;

  localparam logic [16:0] RATE_W = 17'(RATE);

  state_t             r_state;
  logic               r_primed;
  logic               r_in_ready;
  logic               r_out_valid;
  logic signed [15:0] r_cur_x, r_cur_y, r_cur_z;
  logic signed [15:0] r_prev_x, r_prev_y, r_prev_z;
  logic signed [15:0] r_delta_x, r_delta_y, r_delta_z;
  logic signed [15:0] r_pend_x, r_pend_y, r_pend_z;
  logic signed [15:0] r_dx, r_dy, r_dz;
  logic [15:0]        r_dvd, r_rem, r_quo;
  logic [3:0]         r_cnt;
  logic [1:0]         r_axis;

  logic signed [15:0] w_sat_x, w_sat_y, w_sat_z;
  logic signed [15:0] w_delta_sel;
  logic               w_neg;
  logic [15:0]        w_mag, w_dvd_src, w_quo_next, w_result;
  logic [16:0]        w_rem_shift, w_rem_next;
  logic               w_ge;

  // The 17-bit difference cannot overflow; clamp symmetric so -32768 never appears.
  function automatic logic signed [15:0] sat_delta(input logic signed [15:0] cur,
                                                    input logic signed [15:0] prev);
    logic signed [16:0] d;
    d = {cur[15], cur} - {prev[15], prev};
    if (d > 17'sd32767)       return 16'sd32767;
    else if (d < -17'sd32767) return -16'sd32767;
    else                      return d[15:0];
  endfunction

  assign w_sat_x = sat_delta(r_cur_x, r_prev_x);
  assign w_sat_y = sat_delta(r_cur_y, r_prev_y);
  assign w_sat_z = sat_delta(r_cur_z, r_prev_z);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_delta_sel = r_delta_x;
    case (r_axis)
      2'd1:    w_delta_sel = r_delta_y;
      2'd2:    w_delta_sel = r_delta_z;
      default: w_delta_sel = r_delta_x;
    endcase
  end

  // Divider operates on the magnitude; the sign is reapplied to the finished quotient.
  assign w_neg       = w_delta_sel[15];
  assign w_mag       = w_neg ? 16'(-w_delta_sel) : 16'(w_delta_sel);
  assign w_dvd_src   = (r_cnt == 4'd0) ? w_mag : r_dvd;
  assign w_rem_shift = {r_rem, w_dvd_src[15]};
  assign w_ge        = (w_rem_shift >= RATE_W);
  assign w_rem_next  = w_ge ? (w_rem_shift - RATE_W) : w_rem_shift;
  assign w_quo_next  = {r_quo[14:0], w_ge};
  assign w_result    = w_neg ? (16'd0 - w_quo_next) : w_quo_next;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its peers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_primed    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_cur_z     <= '0;
      r_prev_x    <= '0;
      r_prev_y    <= '0;
      r_prev_z    <= '0;
      r_delta_x   <= '0;
      r_delta_y   <= '0;
      r_delta_z   <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_z    <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_dz        <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_axis      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cur_x    <= X;
            r_cur_y    <= Y;
            r_cur_z    <= Z;
            r_in_ready <= 1'b0;
            r_state    <= SUB;
          end
        end

        SUB: begin
          r_delta_x <= r_primed ? w_sat_x : 16'sd0;
          r_delta_y <= r_primed ? w_sat_y : 16'sd0;
          r_delta_z <= r_primed ? w_sat_z : 16'sd0;
          r_prev_x  <= r_cur_x;
          r_prev_y  <= r_cur_y;
          r_prev_z  <= r_cur_z;
          r_primed  <= 1'b1;
          r_axis    <= 2'd0;
          r_cnt     <= 4'd0;
          r_rem     <= '0;
          r_quo     <= '0;
          r_state   <= DIV;
        end

        DIV: begin
          r_dvd <= {w_dvd_src[14:0], 1'b0};
          r_rem <= w_rem_next[15:0];
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_rem <= '0;
            r_quo <= '0;
            case (r_axis)
              2'd0:    r_pend_x <= w_result;
              2'd1:    r_pend_y <= w_result;
              default: r_pend_z <= w_result;
            endcase
            if (r_axis == 2'd2) r_state <= OUT;
            else                r_axis  <= r_axis + 2'd1;
          end
        end

        OUT: begin
          // First OUT cycle publishes the results; later cycles wait for the handshake.
          if (!r_out_valid) begin
            r_dx        <= r_pend_x;
            r_dy        <= r_pend_y;
            r_dz        <= r_pend_z;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dx        = r_dx;
  assign dy        = r_dy;
  assign dz        = r_dz;

endmodule

// File: tb/tb_gyro_rate_deriv.sv
// Self-checking bench for gyro_rate_deriv: directed corner cases plus random
// samples compared against an arithmetic rate model.
module tb_gyro_rate_deriv;

  localparam int RATE = 10;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [15:0] X, Y, Z;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] dx, dy, dz;
  logic               out_valid;
  logic               out_ready;

  int n_total = 0;
  int n_bad   = 0;

  int m_prev[3];
  bit m_primed;

  gyro_rate_deriv #(.RATE(RATE), .WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dx        (dx),
    .dy        (dy),
    .dz        (dz),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int model_rate(input int cur, input int prev);
    int d;
    d = cur - prev;
    if (d > 32767)  d = 32767;
    if (d < -32767) d = -32767;
    return d / RATE;
  endfunction

  function automatic int rnd_sample(input int prev);
    int v;
    if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 65535)) - 32768;
    else begin
      v = prev + int'($urandom_range(0, 1000)) - 500;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
    end
    return v;
  endfunction

  task automatic run_sample(input int x, input int y, input int z,
                            input bit hold, input string tag);
    int ex, ey, ez, lat;
    bit busy_ok;
    ex = m_primed ? model_rate(x, m_prev[0]) : 0;
    ey = m_primed ? model_rate(y, m_prev[1]) : 0;
    ez = m_primed ? model_rate(z, m_prev[2]) : 0;
    m_prev[0] = x; m_prev[1] = y; m_prev[2] = z;
    m_primed  = 1'b1;

    @(negedge CLK);
    chk({tag, "_rdy_idle"}, in_ready, 1);
    X = 16'(x); Y = 16'(y); Z = 16'(z);
    in_valid  = 1'b1;
    out_ready = !hold;
    @(posedge CLK);

    lat = 0;
    busy_ok = 1'b1;
    while (lat <= 60) begin
      @(negedge CLK);
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      X = 16'($urandom); Y = 16'($urandom); Z = 16'($urandom);
      @(posedge CLK);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 50);
    chk({tag, "_busy_rdy"}, busy_ok, 1);
    chk({tag, "_dx"}, dx, ex);
    chk({tag, "_dy"}, dy, ey);
    chk({tag, "_dz"}, dz, ez);

    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        X = 16'($urandom); Y = 16'($urandom); Z = 16'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_hold_ov"}, out_valid, 1);
        chk({tag, "_hold_rdy"}, in_ready, 0);
        chk({tag, "_hold_dx"}, dx, ex);
        chk({tag, "_hold_dy"}, dy, ey);
        chk({tag, "_hold_dz"}, dz, ez);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end

    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
    chk({tag, "_dx_kept"}, dx, ex);
    chk({tag, "_dz_kept"}, dz, ez);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; Z = '0;
    m_prev = '{0, 0, 0};
    m_primed = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_dx", dx, 0);
    chk("rst_dy", dy, 0);
    chk("rst_dz", dz, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("idle_rdy", in_ready, 1);
    end

    run_sample(100, -50, 0, 1'b0, "first");
    run_sample(200, -150, 7, 1'b0, "step");
    run_sample(200, -150, 0, 1'b0, "zback");
    run_sample(200, -150, -7, 1'b0, "ztrunc");
    run_sample(-30000, 0, 0, 1'b0, "sat_a");
    run_sample(30000, 0, 0, 1'b0, "sat_pos");
    run_sample(-30000, 32767, -32768, 1'b0, "sat_neg");
    run_sample(1234, -4321, 99, 1'b1, "hold");

    for (int i = 0; i < 12; i++)
      run_sample(rnd_sample(m_prev[0]), rnd_sample(m_prev[1]),
                 rnd_sample(m_prev[2]), 1'($urandom_range(0, 3) == 0), "rand");

    run_sample(9000, -9000, 450, 1'b0, "pre_rst");
    @(negedge CLK);
    X = 16'sd20000; Y = -16'sd20000; Z = 16'sd77;
    in_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_dx", dx, 0);
    chk("midrst_dy", dy, 0);
    chk("midrst_dz", dz, 0);
    chk("midrst_rdy", in_ready, 1);
    m_prev = '{0, 0, 0};
    m_primed = 1'b0;
    run_sample(500, 0, 0, 1'b0, "unprimed");
    run_sample(800, -300, 25, 1'b0, "reprimed");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
